// File: rtl/moore_mod_counter_pkg.sv
// Shared types and next-state helper for the modulo Moore counter.
// Direction, operation priority and wrap/next bundle live here.
package moore_mod_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Highest value wins: clear > load > count > hold.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_COUNT = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    localparam int unsigned FN_W = 32;

    typedef struct packed {
        logic            wrap;
        logic [FN_W-1:0] next;
    } step_t;

    function automatic step_t next_mod_state(
        input logic [FN_W-1:0] state,
        input dir_e            dir,
        input logic [FN_W-1:0] modulus
    );
        step_t           r;
        logic [FN_W-1:0] last;
        last   = modulus - 32'd1;
        r.wrap = 1'b0;
        r.next = state;
        if (dir == DIR_UP) begin
            if (state == last) begin
                r.next = '0;
                r.wrap = 1'b1;
            end else begin
                r.next = state + 32'd1;
            end
        end else begin
            if (state == '0) begin
                r.next = last;
                r.wrap = 1'b1;
            end else begin
                r.next = state - 32'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/moore_mod_next.sv
// Combinational modulo step: next state and wrap flag for one count.
// Bounds are compared before stepping, so no wider intermediate escapes.
module moore_mod_next
    import moore_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 4
) (
    input  logic [WIDTH-1:0] state_i,
    input  dir_e             dir_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o
);

    step_t res;
    logic  unused_hi;

    assign res = next_mod_state(FN_W'(state_i), dir_i, FN_W'(MODULUS));

    assign next_o    = res.next[WIDTH-1:0];
    assign wrap_o    = res.wrap;
    assign unused_hi = &{1'b0, res.next[FN_W-1:WIDTH]};

endmodule

// File: rtl/moore_mod_counter.sv
// Modulo-N up/down Moore counter with clear, load and wrap flag.
// Define MOORE_MOD_COUNTER_HIT_LATCH_EN to add the sticky hit_seen output.
module moore_mod_counter
    import moore_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int MODULUS  = 4,
    parameter int TERMINAL = MODULUS - 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_in,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state_out,
    output logic             y_out,
`ifdef MOORE_MOD_COUNTER_HIT_LATCH_EN
    output logic             hit_seen,
`endif
    output logic             wrap_out
);

    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $error("moore_mod_counter: WIDTH out of range");
    end
    if (MODULUS < 2 ||
        longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_mod
        $error("moore_mod_counter: MODULUS out of range");
    end
    if (TERMINAL < 0 || TERMINAL >= MODULUS) begin : g_bad_term
        $error("moore_mod_counter: TERMINAL out of range");
    end

    localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TERM_W = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] cnt_next;
    logic             wrap_q;
    logic             wrap_d;
    logic             cnt_wrap;
    logic             load_ok;
    op_e              op;

    moore_mod_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .state_i (state_q),
        .dir_i   (dir_e'(up_dn)),
        .next_o  (cnt_next),
        .wrap_o  (cnt_wrap)
    );

    assign load_ok = ({1'b0, load_value} < MOD_W);

    always_comb begin
        op = OP_HOLD;
        if (clear) begin
            op = OP_CLEAR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (x_in) begin
            op = OP_COUNT;
        end
    end

    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        unique case (op)
            OP_CLEAR: state_d = '0;
            OP_LOAD: begin
                // Out-of-range loads are dropped, and x_in is ignored too.
                if (load_ok) begin
                    state_d = load_value;
                end
            end
            OP_COUNT: begin
                state_d = cnt_next;
                wrap_d  = cnt_wrap;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
        end
    end

    assign state_out = state_q;
    assign y_out     = (state_q == TERM_W);
    assign wrap_out  = wrap_q;

`ifdef MOORE_MOD_COUNTER_HIT_LATCH_EN
    logic hit_q;
    logic hit_d;

    always_comb begin
        hit_d = hit_q;
        if (op == OP_CLEAR) begin
            hit_d = 1'b0;
        end else if ((op == OP_COUNT || (op == OP_LOAD && load_ok)) &&
                     state_d == TERM_W) begin
            hit_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_seen = hit_q;
`endif

endmodule

// File: tb/tb_moore_mod_counter.sv
// Bench for moore_mod_counter: default instance (mod 4) and a mod-5 one
// (WIDTH=3, TERMINAL=2) driven from shared inputs, checked via a queue.
module tb_moore_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x   = 1'b0;
    logic       up  = 1'b1;
    logic       clr = 1'b0;
    logic       ld  = 1'b0;
    logic [2:0] lv  = 3'd0;

    logic [1:0] st_a;
    logic       y_a;
    logic       w_a;
    logic [2:0] st_b;
    logic       y_b;
    logic       w_b;
`ifdef MOORE_MOD_COUNTER_HIT_LATCH_EN
    logic       h_a;
    logic       h_b;
`endif

    always #5 clk = ~clk;

    moore_mod_counter u_a (
        .clock      (clk),
        .reset      (rst),
        .x_in       (x),
        .up_dn      (up),
        .clear      (clr),
        .load       (ld),
        .load_value (lv[1:0]),
        .state_out  (st_a),
        .y_out      (y_a),
`ifdef MOORE_MOD_COUNTER_HIT_LATCH_EN
        .hit_seen   (h_a),
`endif
        .wrap_out   (w_a)
    );

    moore_mod_counter #(
        .WIDTH    (3),
        .MODULUS  (5),
        .TERMINAL (2)
    ) u_b (
        .clock      (clk),
        .reset      (rst),
        .x_in       (x),
        .up_dn      (up),
        .clear      (clr),
        .load       (ld),
        .load_value (lv),
        .state_out  (st_b),
        .y_out      (y_b),
`ifdef MOORE_MOD_COUNTER_HIT_LATCH_EN
        .hit_seen   (h_b),
`endif
        .wrap_out   (w_b)
    );

    typedef struct {
        logic       x, up, clr, ld;
        logic [2:0] lv;
        logic [1:0] sa;
        logic       ya, wa, ha;
        logic [2:0] sb;
        logic       yb, wb, hb;
    } vec_t;

    vec_t tbl[18];
    vec_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        input int xi, upi, ci, li, lvi,
        input int sa, ya, wa, ha,
        input int sb, yb, wb, hb
    );
        vec_t v;
        v.x   = (xi != 0);
        v.up  = (upi != 0);
        v.clr = (ci != 0);
        v.ld  = (li != 0);
        v.lv  = 3'(lvi);
        v.sa  = 2'(sa);
        v.ya  = (ya != 0);
        v.wa  = (wa != 0);
        v.ha  = (ha != 0);
        v.sb  = 3'(sb);
        v.yb  = (yb != 0);
        v.wb  = (wb != 0);
        v.hb  = (hb != 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag);
        vec_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sbq.pop_front();
        chk({tag, " st_a"}, 32'(st_a), 32'(e.sa));
        chk({tag, " y_a"},  32'(y_a),  32'(e.ya));
        chk({tag, " w_a"},  32'(w_a),  32'(e.wa));
        chk({tag, " st_b"}, 32'(st_b), 32'(e.sb));
        chk({tag, " y_b"},  32'(y_b),  32'(e.yb));
        chk({tag, " w_b"},  32'(w_b),  32'(e.wb));
`ifdef MOORE_MOD_COUNTER_HIT_LATCH_EN
        chk({tag, " h_a"},  32'(h_a),  32'(e.ha));
        chk({tag, " h_b"},  32'(h_b),  32'(e.hb));
`endif
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        rst = 1'b1;
        x   = v.x;
        up  = v.up;
        clr = v.clr;
        ld  = v.ld;
        lv  = v.lv;
        sbq.push_back(v);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        //        x up c l lv   A:st y w h   B:st y w h
        tbl[0]  = mk(1,1,0,0,0,  1,0,0,0,  1,0,0,0);
        tbl[1]  = mk(1,1,0,0,0,  2,0,0,0,  2,1,0,1);
        tbl[2]  = mk(1,1,0,0,0,  3,1,0,1,  3,0,0,1);
        tbl[3]  = mk(1,1,0,0,0,  0,0,1,1,  4,0,0,1);
        tbl[4]  = mk(1,1,0,0,0,  1,0,0,1,  0,0,1,1);
        tbl[5]  = mk(1,0,0,0,0,  0,0,0,1,  4,0,1,1);
        tbl[6]  = mk(1,0,0,0,0,  3,1,1,1,  3,0,0,1);
        tbl[7]  = mk(1,0,0,0,0,  2,0,0,1,  2,1,0,1);
        tbl[8]  = mk(1,0,0,0,0,  1,0,0,1,  1,0,0,1);
        tbl[9]  = mk(1,0,0,0,0,  0,0,0,1,  0,0,0,1);
        tbl[10] = mk(1,0,0,0,0,  3,1,1,1,  4,0,1,1);
        tbl[11] = mk(0,1,0,0,0,  3,1,0,1,  4,0,0,1);
        tbl[12] = mk(0,1,0,1,3,  3,1,0,1,  3,0,0,1);
        tbl[13] = mk(1,1,0,1,6,  2,0,0,1,  3,0,0,1);
        tbl[14] = mk(1,1,0,1,7,  3,1,0,1,  3,0,0,1);
        tbl[15] = mk(1,1,1,1,1,  0,0,0,0,  0,0,0,0);
        tbl[16] = mk(1,1,0,0,0,  1,0,0,0,  1,0,0,0);
        tbl[17] = mk(1,1,0,0,0,  2,0,0,0,  2,1,0,1);

        #1 rst = 1'b0;
        #1;
        sbq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        check_out("reset");

        for (int i = 0; i < 18; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Async reset between edges with A at 2, B at 2.
        #2 rst = 1'b0;
        #1;
        sbq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        check_out("midrst");

        // Release at the negedge; first edge afterwards counts to 1.
        step(mk(1,1,0,0,0, 1,0,0,0, 1,0,0,0), "resume");
        step(mk(0,0,0,0,0, 1,0,0,0, 1,0,0,0), "hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
